// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Asynchronous serial receiver (8N1 by default, LSB first, idle
//            high). Oversamples the line with clk, samples each bit at its
//            mid-point and presents the word with a one-cycle strobe.
// Ports    : clk       - system clock, rising edge
//            reset     - synchronous, active-high reset
//            rxd       - serial line, asynchronous to clk, idle high
//            data      - last received word, bit 0 = first bit on the wire
//            finished  - one-cycle pulse when a frame completes
//            frame_err - (UART_RX_FRAME_ERR_EN only) pulses with finished
//                        when any stop sample was 0
// Options  : `define UART_RX_FRAME_ERR_EN to add the frame_err output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int BAUD_RATE = 9600,
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int STOP_BITS = 1,
    parameter int N_BITS    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic [N_BITS-1:0] data,
    output logic              finished
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int c_clks_per_bit = CLOCK_HZ / BAUD_RATE;
    localparam int c_half         = c_clks_per_bit / 2;
    localparam int c_cnt_w        = $clog2(c_clks_per_bit + 1);
    localparam int c_idx_w        = $clog2(N_BITS);

    localparam logic [c_cnt_w-1:0] c_cpb_m1  = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(c_half - 1);
    localparam logic [c_idx_w-1:0] c_last_bit  = c_idx_w'(N_BITS - 1);
    localparam logic               c_last_stop = 1'(STOP_BITS - 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_start     = 3'd1;
    localparam logic [2:0] c_st_data      = 3'd2;
    localparam logic [2:0] c_st_stop      = 3'd3;
    localparam logic [2:0] c_st_wait_idle = 3'd4;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    logic r_sync_meta;
    logic r_rxs;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_bit_idx;
    logic               r_stop_idx;
    logic [N_BITS-1:0]  r_shift;
    logic [N_BITS-1:0]  r_data;
    logic               r_finished;

    logic w_tick_half;
    logic w_tick_bit;
    logic w_last_bit;
    logic w_last_stop;

    logic w_cnt_clear;
    logic w_start_ok;
    logic w_shift_en;
    logic w_stop_en;
    logic w_frame_done;

    assign w_tick_half = (r_cnt == c_half_m1);
    assign w_tick_bit  = (r_cnt == c_cpb_m1);
    assign w_last_bit  = (r_bit_idx == c_last_bit);
    assign w_last_stop = (r_stop_idx == c_last_stop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_meta <= 1'b1;
            r_rxs       <= 1'b1;
        end else begin
            r_sync_meta <= rxd;
            r_rxs       <= r_sync_meta;
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (!r_rxs) begin
                    w_state_next = c_st_start;
                end
            end
            c_st_start: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (w_tick_half) begin
                    w_state_next = r_rxs ? c_st_idle : c_st_data;
                end
            end
            c_st_data: begin
                if (w_tick_bit && w_last_bit) begin
                    w_state_next = c_st_stop;
                end
            end
            c_st_stop: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be
                // seen; a low stop bit means the line may be in break, so
                // wait for it to go high before hunting for a start edge.
                if (w_tick_bit && w_last_stop) begin
                    w_state_next = r_rxs ? c_st_idle : c_st_wait_idle;
                end
            end
            c_st_wait_idle: begin
                if (r_rxs) begin
                    w_state_next = c_st_idle;
                end
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        w_cnt_clear  = 1'b0;
        w_start_ok   = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_en    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_cnt_clear = 1'b1;
            end
            c_st_start: begin
                if (w_tick_half) begin
                    w_cnt_clear = 1'b1;
                    w_start_ok  = ~r_rxs;
                end
            end
            c_st_data: begin
                if (w_tick_bit) begin
                    w_cnt_clear = 1'b1;
                    w_shift_en  = 1'b1;
                end
            end
            c_st_stop: begin
                if (w_tick_bit) begin
                    w_cnt_clear  = 1'b1;
                    w_stop_en    = 1'b1;
                    w_frame_done = w_last_stop;
                end
            end
            default: begin
                w_cnt_clear = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_data     <= '0;
            r_finished <= 1'b0;
        end else begin
            if (w_cnt_clear) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_start_ok) begin
                r_bit_idx  <= '0;
                r_stop_idx <= 1'b0;
            end else begin
                if (w_shift_en) begin
                    r_bit_idx <= r_bit_idx + c_idx_w'(1);
                end
                if (w_stop_en) begin
                    r_stop_idx <= r_stop_idx + 1'b1;
                end
            end

            // Shift right so the first bit on the wire ends up at bit 0.
            if (w_shift_en) begin
                r_shift <= {r_rxs, r_shift[N_BITS-1:1]};
            end

            r_finished <= w_frame_done;
            if (w_frame_done) begin
                r_data <= r_shift;
            end
        end
    end

    assign data     = r_data;
    assign finished = r_finished;

`ifdef UART_RX_FRAME_ERR_EN
    logic r_stop_ok;
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stop_ok   <= 1'b1;
            r_frame_err <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_stop_ok <= 1'b1;
            end else if (w_stop_en) begin
                r_stop_ok <= r_stop_ok & r_rxs;
            end
            // The last stop sample is folded in here since r_stop_ok only
            // catches up with it on this same edge.
            r_frame_err <= w_frame_done & ~(r_stop_ok & r_rxs);
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx with a short bit period.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int BAUD_RATE = 100_000;
    localparam int CLOCK_HZ  = 1_600_000;
    localparam int STOP_BITS = 1;
    localparam int N_BITS    = 8;
    localparam int CPB       = CLOCK_HZ / BAUD_RATE;  // 16
    localparam int HALF      = CPB / 2;               // 8
    // Synchronizer (2) plus the FSM edge that first sees rxs low (1).
    localparam int LAT       = 3;
    localparam int TOL       = 3;

    typedef struct {
        logic [7:0] d;
        logic       err;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] data;
    logic       finished;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         pulse_count = 0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_data = 8'h00;
    exp_t       exp_q[$];

    uart_rx #(
        .BAUD_RATE (BAUD_RATE),
        .CLOCK_HZ  (CLOCK_HZ),
        .STOP_BITS (STOP_BITS),
        .N_BITS    (N_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .data     (data),
        .finished (finished)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: a frame launched at cycle s must strobe at
    // s + LAT + HALF + (N_BITS+STOP_BITS)*CPB, carrying its payload.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset) begin
            check("reset_data", {24'h0, data}, 32'h0);
            check("reset_finished", {31'h0, finished}, 32'h0);
            exp_data = 8'h00;
        end else if (finished) begin
            pulse_count++;
            last_data = data;
            if (exp_q.size() == 0) begin
                check("spurious_finished", {31'h0, finished}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("frame_data", {24'h0, data}, {24'h0, e.d});
                check("frame_not_early", {31'h0, (cyc >= e.due - TOL)}, 32'h1);
                check("frame_not_late", {31'h0, (cyc <= e.due + TOL)}, 32'h1);
`ifdef UART_RX_FRAME_ERR_EN
                check("frame_err_pulse", {31'h0, frame_err}, {31'h0, e.err});
`endif
                exp_data = e.d;
            end
        end else begin
            check("data_hold", {24'h0, data}, {24'h0, exp_data});
`ifdef UART_RX_FRAME_ERR_EN
            check("frame_err_quiet", {31'h0, frame_err}, 32'h0);
`endif
            if (exp_q.size() != 0 && cyc > exp_q[0].due + TOL) begin
                check("missing_finished", {31'h0, finished}, 32'h1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic hold_line(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        exp_t e;
        e.d   = d;
        e.err = ~stop_val;
        e.due = cyc + LAT + HALF + (N_BITS + STOP_BITS) * CPB;
        exp_q.push_back(e);
        hold_line(1'b0, CPB);
        for (int i = 0; i < N_BITS; i++) begin
            hold_line(d[i], CPB);
        end
        hold_line(stop_val, CPB);
    endtask

    task automatic wait_pulses(input int target);
        int budget;
        budget = 40 * CPB;
        while (pulse_count < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check("pulse_count", pulse_count, target);
    endtask

    initial begin
        logic [7:0] part;
        reset = 1'b1;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle line: nothing received.
        hold_line(1'b1, 10 * CPB);
        check("idle_data", {24'h0, data}, 32'h00);
        check("idle_pulses", pulse_count, 0);

        // Basic frame.
        send_frame(8'h56, 1'b1);
        hold_line(1'b1, 2 * CPB);
        wait_pulses(1);
        check("basic_value", {24'h0, last_data}, 32'h56);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1);
        hold_line(1'b1, 2 * CPB);
        wait_pulses(4);
        check("b2b_last_value", {24'h0, last_data}, 32'hA5);

        // Glitch shorter than half a bit, then a real frame.
        hold_line(1'b0, 3);
        hold_line(1'b1, 2 * CPB);
        check("glitch_no_pulse", pulse_count, 4);
        send_frame(8'h3C, 1'b1);
        hold_line(1'b1, 2 * CPB);
        wait_pulses(5);
        check("after_glitch_value", {24'h0, last_data}, 32'h3C);

        // Reset in the middle of data bit 4 of a 0x81 frame.
        part = 8'h81;
        hold_line(1'b0, CPB);
        for (int i = 0; i < 4; i++) begin
            hold_line(part[i], CPB);
        end
        hold_line(part[4], CPB / 2);
        reset = 1'b1;
        rxd   = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        hold_line(1'b1, 2 * CPB);
        check("midreset_pulses", pulse_count, 5);
        check("midreset_data", {24'h0, data}, 32'h00);
        send_frame(8'h81, 1'b1);
        hold_line(1'b1, 2 * CPB);
        wait_pulses(6);
        check("after_reset_value", {24'h0, last_data}, 32'h81);

        // Framing error: stop bit low, line stays low for a while.
        send_frame(8'h56, 1'b0);
        hold_line(1'b0, 5 * CPB);
        wait_pulses(7);
        check("framing_value", {24'h0, last_data}, 32'h56);
        hold_line(1'b1, 2 * CPB);
        check("break_no_retrigger", pulse_count, 7);
        send_frame(8'h12, 1'b1);
        hold_line(1'b1, 2 * CPB);
        wait_pulses(8);
        check("after_break_value", {24'h0, last_data}, 32'h12);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
